hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage CPU, sitting beside the forwarding logic between the ID and EX stages. It detects load-use hazards that forwarding cannot cover and stalls PC and IF/ID while bubbling ID/EX. It also sequences the multi-cycle multiply/divide unit (MDU) and stalls any HI/LO-dependent instruction until the result is written. Taken branches resolved in EX flush the wrong-path instructions, and a saturating counter records stall cycles for performance analysis.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_mdu_sequencer.sv | 69 ++++++
 rtl/hazard_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions used by the hazard controller: MDU state encoding,
// default MDU latencies and the down-counter width helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;

    // Width able to hold (max latency - 1); never narrower than one bit.
    function automatic int mdu_cnt_w(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return ($clog2(mx) > 0) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_sequencer.sv
// Multi-cycle MDU sequencer: IDLE -> BUSY (latency count) -> DONE -> IDLE.
// A start is honoured only in IDLE and only when no taken branch squashes it.
module mdu_sequencer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ex_MduStart,
    input  logic ex_MduIsDiv,
    input  logic branch_taken,
    output logic mdu_busy,
    output logic mdu_done
);

    localparam int CNT_W = mdu_cnt_w(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_IDLE: begin
                if (ex_MduStart && !branch_taken) begin
                    state_d = MDU_BUSY;
                    cnt_d   = ex_MduIsDiv ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MDU_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mdu_busy = (state_q != MDU_IDLE);
    assign mdu_done = (state_q == MDU_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO-dependency stalls, branch
// flush priority, MDU sequencing and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_Rs,
    input  logic [4:0]  id_Rt,
    input  logic        id_UseRs,
    input  logic        id_UseRt,
    input  logic        id_MduUse,
    input  logic        exe_MemRead,
    input  logic [4:0]  exe_RegisterRt,
    input  logic        ex_MduStart,
    input  logic        ex_MduIsDiv,
    input  logic        branch_taken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [15:0] stall_cnt
);

    logic        load_use_s;
    logic        mdu_stall_s;
    logic        stall_s;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    mdu_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_MduStart  (ex_MduStart),
        .ex_MduIsDiv  (ex_MduIsDiv),
        .branch_taken (branch_taken),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done)
    );

    // Hazard detection and the branch > stall > pass priority mux.
    always_comb begin
        load_use_s  = exe_MemRead && (exe_RegisterRt != 5'd0) &&
                      ((id_UseRs && (id_Rs == exe_RegisterRt)) ||
                       (id_UseRt && (id_Rt == exe_RegisterRt)));
        mdu_stall_s = id_MduUse && (mdu_busy || ex_MduStart);
        stall_s     = (load_use_s || mdu_stall_s) && !branch_taken;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        if (branch_taken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (stall_s) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            PCWrite     = 1'b1;
        end
    end

    // Saturating stall counter next value; flush-only cycles never count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
